cxd_arrange_fifo: RTL
=====================

CXD_ARRANGE_FIFO -- requirements
Module: cxd_arrange_fifo

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of parallel CX/D input lanes (legal 1..8).
REQ-002 The block SHALL have parameter CXD_W, default 8, giving the width of one CX/D word.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving FIFO entries (power of 2, DEPTH >= 2*LANES).
REQ-004 The block SHALL have port clk_dwt, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_syn, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port pos_clk_bpc, input, 1 bit: input-side capture enable, one clk_dwt cycle per BPC beat.
REQ-007 The block SHALL have port cxd_in, input, LANES*CXD_W bits: lane k occupies bits [k*CXD_W +: CXD_W].
REQ-008 The block SHALL have port cxd_vld, input, LANES bits: per-lane valid.
REQ-009 The block SHALL have port in_rdy, output, 1 bit: high when free entries >= LANES.
REQ-010 The block SHALL have port arrange_out, output, CXD_W bits: head-of-FIFO CX/D word.
REQ-011 The block SHALL have port arrange_out_vld, output, 1 bit: arrange_out holds a valid word.
REQ-012 The block SHALL have port arrange_rdy, input, 1 bit: consumer accepts arrange_out this cycle.
REQ-013 The block SHALL have port fill_cnt, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port ovf_err, output, 1 bit: sticky overflow flag.

Function
REQ-015 The block SHALL perform a write beat when pos_clk_bpc=1, in_rdy=1 and cxd_vld is nonzero.
REQ-016 On a write beat, the block SHALL compact the valid lanes in ascending lane order: the lowest valid lane goes to wr_ptr, the next to wr_ptr+1, and so on.
REQ-017 On a write beat, invalid lanes SHALL be discarded, with no gap left in the FIFO.
REQ-018 On a write beat, wr_ptr SHALL advance by popcount(cxd_vld), modulo DEPTH (wrap-around).
REQ-019 A write attempt with pos_clk_bpc=1, nonzero cxd_vld and in_rdy=0 SHALL drop the whole beat.
REQ-020 On a dropped beat (REQ-019), the block SHALL set ovf_err=1 and hold it until rst_syn.
REQ-021 With pos_clk_bpc=0 or cxd_vld=0, the block SHALL NOT change FIFO contents or wr_ptr.
REQ-022 Output SHALL be first-word-fall-through: arrange_out_vld = (fill_cnt != 0) and arrange_out = mem[rd_ptr].
REQ-023 When fill_cnt=0, arrange_out SHALL be driven to all zeros.
REQ-024 A read SHALL occur when arrange_out_vld=1 and arrange_rdy=1; rd_ptr then advances by 1 modulo DEPTH.
REQ-025 When arrange_rdy=0 with arrange_out_vld=1, arrange_out and arrange_out_vld SHALL hold stable (stall).
REQ-026 When a write beat and a read occur in the same cycle, fill_cnt(next) SHALL equal fill_cnt + popcount(cxd_vld) - 1.
REQ-027 A read of the word at rd_ptr SHALL never be corrupted by a concurrent write.
REQ-028 in_rdy SHALL be derived from registered fill_cnt only, with no combinational path from arrange_rdy.
REQ-029 A word written in cycle t into an empty FIFO SHALL appear on arrange_out with arrange_out_vld=1 in cycle t+1 (latency 1).
REQ-030 The block SHALL guarantee fill_cnt never exceeds DEPTH and never underflows.
REQ-031 Reads with fill_cnt=0 SHALL be ignored.

Reset
REQ-032 On rst_syn=1 at a clk_dwt edge, the block SHALL clear wr_ptr, rd_ptr, fill_cnt and ovf_err to 0.
REQ-033 After reset, the block SHALL drive arrange_out=0, arrange_out_vld=0 and in_rdy=1.
REQ-034 rst_syn SHALL take priority over a simultaneous write or read; data presented in the reset cycle SHALL be discarded.
REQ-035 On reset, FIFO memory contents need not be cleared and SHALL be unobservable.
REQ-036 Reset asserted mid-stream SHALL leave no residual words emitted after deassertion.

Verification (LANES=4, CXD_W=8, DEPTH=16)
REQ-037 The bench SHALL cover reset then idle -> arrange_out_vld=0, arrange_out=0x00, fill_cnt=0, in_rdy=1, ovf_err=0.
REQ-038 The bench SHALL cover sparse compaction: cxd_in lanes {0x11,0x22,0x33,0x44}, cxd_vld=4'b1010, pos_clk_bpc=1, arrange_rdy=1 -> output 0x22 then 0x44 on consecutive cycles, first one cycle after the write, fill_cnt 2->1->0.
REQ-039 The bench SHALL cover fill to full: four beats with cxd_vld=4'b1111 and arrange_rdy=0 -> fill_cnt=16, in_rdy=0 once fill_cnt>12; a fifth beat -> dropped, ovf_err=1, fill_cnt stays 16.
REQ-040 The bench SHALL cover wrap-around: 20 beats of cxd_vld=4'b0011 with arrange_rdy=1 -> 40 words emitted in exact input order across pointer wrap, no loss, ovf_err=0.
REQ-041 The bench SHALL cover simultaneous write and read: fill_cnt=5, write cxd_vld=4'b0111 with a read -> fill_cnt=7, head word unchanged except for the advance.
REQ-042 The bench SHALL cover reset mid-operation: rst_syn=1 for one cycle at fill_cnt=9 with a write beat pending -> fill_cnt=0, arrange_out_vld=0, ovf_err=0 next cycle, no stale words thereafter.

Source files
------------

// File: rtl/cxd_arrange_fifo.sv
// CX/D arrange FIFO: compacts the valid lanes of each multi-lane BPC beat into a
// single-word first-word-fall-through stream, in ascending lane order.
module cxd_arrange_fifo #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CXD_W = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   clk_dwt,
  input  logic                   rst_syn,
  input  logic                   pos_clk_bpc,
  input  logic [LANES*CXD_W-1:0] cxd_in,
  input  logic [LANES-1:0]       cxd_vld,
  output logic                   in_rdy,
  output logic [CXD_W-1:0]       arrange_out,
  output logic                   arrange_out_vld,
  input  logic                   arrange_rdy,
  output logic [AW:0]            fill_cnt,
  output logic                   ovf_err
);

  logic [CXD_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          ovf_q, ovf_d;

  logic [AW:0]   wr_cnt;
  logic [AW-1:0] wr_idx [LANES];
  logic          wr_try;
  logic          wr_en;
  logic          rd_en;

  // A whole beat is only accepted when every lane could fit, so a write can
  // never land on an occupied entry (including the one being read).
  assign in_rdy = (fill_q <= (AW+1)'(DEPTH - LANES));
  assign wr_try = pos_clk_bpc && (|cxd_vld);
  assign wr_en  = wr_try && in_rdy;
  assign rd_en  = (fill_q != '0) && arrange_rdy;

  // Per-lane destination: wr_ptr plus the number of valid lanes below it.
  always_comb begin
    wr_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_idx[k] = wr_ptr_q + wr_cnt[AW-1:0];
      wr_cnt    = wr_cnt + (AW+1)'(cxd_vld[k]);
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + wr_cnt[AW-1:0];
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    fill_d = fill_q + (wr_en ? wr_cnt : '0) - (rd_en ? (AW+1)'(1) : '0);
    if (wr_try && !in_rdy) begin
      ovf_d = 1'b1;
    end
  end

  // State register; reset wins over any concurrent read or write.
  always_ff @(posedge clk_dwt) begin
    if (rst_syn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write; contents are left as-is on reset since fill_cnt hides them.
  always_ff @(posedge clk_dwt) begin
    if (!rst_syn && wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (cxd_vld[k]) begin
          mem[wr_idx[k]] <= cxd_in[k*CXD_W +: CXD_W];
        end
      end
    end
  end

  // First-word-fall-through head, forced to zero when empty.
  always_comb begin
    arrange_out_vld = (fill_q != '0);
    arrange_out     = arrange_out_vld ? mem[rd_ptr_q] : '0;
    fill_cnt        = fill_q;
    ovf_err         = ovf_q;
  end

endmodule
